writeback_drain: RTL

- Consumer end of the execution-stage writeback bundle (two GPR write requests plus CR update per cycle).
- Buffers GPR writes in a small FIFO and drains them one per cycle into the single GPR-file write port.
- Applies CR updates to the architectural CR.
- Exports a pending-write mask for reg-read hazard checks, and back-pressure to execution.

---
 rtl/writeback_drain_pkg.sv | 24 ++
 rtl/writeback_drain_fifo.sv | 95 +++++++++
 rtl/writeback_drain.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/writeback_drain_pkg.sv
// Shared definitions for the writeback drain slice.
// Holds the functional-unit codes and the canonical writeback entry layout
// at the default GPR address and data widths.
package writeback_drain_pkg;

    localparam int unsigned WB_REG_WIDTH  = 5;
    localparam int unsigned WB_DATA_WIDTH = 64;
    localparam int unsigned WB_UNIT_WIDTH = 3;

    typedef enum logic [WB_UNIT_WIDTH-1:0] {
        FU_FX     = 3'd0,
        FU_FP     = 3'd1,
        FU_LDST   = 3'd2,
        FU_BRANCH = 3'd3,
        FU_TRAP   = 3'd4
    } fu_code_e;

    typedef struct packed {
        logic [WB_UNIT_WIDTH-1:0] unit;
        logic [WB_REG_WIDTH-1:0]  addr;
        logic [WB_DATA_WIDTH-1:0] val;
    } wb_entry_t;

endpackage

// File: rtl/writeback_drain_fifo.sv
// wb_fifo: circular buffer accepting up to two writes and releasing one
// entry per cycle.
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   push0_*/push1_*           write slots; slot 1 is only used together
//                             with slot 0 (caller compacts requests)
//   pop                       release head entry (ignored when empty)
//   head_unit/addr/val        current head entry
//   count                     number of queued entries
//   entry_valid/entry_addr    per-slot occupancy and destination address
module wb_fifo
    import writeback_drain_pkg::*;
#(
    parameter int unsigned regWidth   = WB_REG_WIDTH,
    parameter int unsigned dataWidth  = WB_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  push0_en,
    input  logic [WB_UNIT_WIDTH-1:0]              push0_unit,
    input  logic [regWidth-1:0]                   push0_addr,
    input  logic [dataWidth-1:0]                  push0_val,
    input  logic                                  push1_en,
    input  logic [WB_UNIT_WIDTH-1:0]              push1_unit,
    input  logic [regWidth-1:0]                   push1_addr,
    input  logic [dataWidth-1:0]                  push1_val,
    input  logic                                  pop,
    output logic [WB_UNIT_WIDTH-1:0]              head_unit,
    output logic [regWidth-1:0]                   head_addr,
    output logic [dataWidth-1:0]                  head_val,
    output logic [CNT_W-1:0]                      count,
    output logic [FIFO_DEPTH-1:0]                 entry_valid,
    output logic [FIFO_DEPTH-1:0][regWidth-1:0]   entry_addr
);

    typedef struct packed {
        logic [WB_UNIT_WIDTH-1:0] unit;
        logic [regWidth-1:0]      addr;
        logic [dataWidth-1:0]     val;
    } entry_t;

    entry_t           mem [FIFO_DEPTH];
    entry_t           push0_entry;
    entry_t           push1_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_plus1;
    logic [CNT_W-1:0] n_push;
    logic             pop_ok;

    assign push0_entry  = {push0_unit, push0_addr, push0_val};
    assign push1_entry  = {push1_unit, push1_addr, push1_val};
    assign wr_ptr_plus1 = wr_ptr + PTR_W'(1);
    assign n_push       = CNT_W'(push0_en) + CNT_W'(push1_en);
    assign pop_ok       = pop && (count != '0);

    assign head_unit = mem[rd_ptr].unit;
    assign head_addr = mem[rd_ptr].addr;
    assign head_val  = mem[rd_ptr].val;

    always_ff @(posedge clock) begin
        if (push0_en) mem[wr_ptr]       <= push0_entry;
        if (push1_en) mem[wr_ptr_plus1] <= push1_entry;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(pop_ok);
            count  <= count + n_push - CNT_W'(pop_ok);
        end
    end

    // A slot is occupied when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        entry_addr  = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = {1'b0, offset} < count;
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/writeback_drain.sv
// writeback_drain: consumer of the execution writeback bundle.
// Queues up to two GPR writes per cycle and drains one per cycle into the
// GPR-file write port; applies CR updates directly.
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   enable_i                    bundle valid
//   functionalUnitCode_i        producing unit
//   reg{1,2}Writeback*_i        two GPR write requests (reg1 queued first)
//   condRegUpdateEnable_i       CR update request, newCRVal_i its value
//   stall_o                     fewer than two free slots
//   regWrite*_o                 registered GPR-file write port
//   condRegWriteEnable_o        one-cycle pulse on CR update
//   condReg_o                   architectural CR bits 32:63
//   pendingMask_o               GPRs with a write queued or in flight
//   empty_o                     queue empty
//   overflow_o                  sticky: bundle offered while stalled
module writeback_drain
    import writeback_drain_pkg::*;
#(
    parameter int unsigned regWidth   = WB_REG_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned dataWidth  = WB_DATA_WIDTH
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [2:0]               functionalUnitCode_i,
    input  logic                     reg1WritebackEnable_i,
    input  logic                     reg2WritebackEnable_i,
    input  logic [regWidth-1:0]      reg1WritebackAddress_i,
    input  logic [regWidth-1:0]      reg2WritebackAddress_i,
    input  logic [dataWidth-1:0]     reg1WritebackVal_i,
    input  logic [dataWidth-1:0]     reg2WritebackVal_i,
    input  logic                     condRegUpdateEnable_i,
    input  logic [31:0]              newCRVal_i,
    output logic                     stall_o,
    output logic                     regWriteEnable_o,
    output logic [regWidth-1:0]      regWriteAddress_o,
    output logic [dataWidth-1:0]     regWriteVal_o,
    output logic [2:0]               regWriteUnit_o,
    output logic                     condRegWriteEnable_o,
    output logic [31:0]              condReg_o,
    output logic [2**regWidth-1:0]   pendingMask_o,
    output logic                     empty_o,
    output logic                     overflow_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                                 accept;
    logic                                 push0_en;
    logic                                 push1_en;
    logic [regWidth-1:0]                  push0_addr;
    logic [dataWidth-1:0]                 push0_val;
    logic                                 pop;
    logic [WB_UNIT_WIDTH-1:0]             head_unit;
    logic [regWidth-1:0]                  head_addr;
    logic [dataWidth-1:0]                 head_val;
    logic [CNT_W-1:0]                     fifo_count;
    logic [CNT_W-1:0]                     free_slots;
    logic [FIFO_DEPTH-1:0]                entry_valid;
    logic [FIFO_DEPTH-1:0][regWidth-1:0]  entry_addr;

    assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign stall_o    = free_slots < CNT_W'(2);
    assign empty_o    = (fifo_count == '0);
    assign accept     = enable_i && !stall_o;
    assign pop        = !empty_o;

    // Compact the two requests so slot 0 always carries the earlier write;
    // slot 1 is only used when both requests are present.
    assign push0_en   = accept && (reg1WritebackEnable_i || reg2WritebackEnable_i);
    assign push1_en   = accept && reg1WritebackEnable_i && reg2WritebackEnable_i;
    assign push0_addr = reg1WritebackEnable_i ? reg1WritebackAddress_i : reg2WritebackAddress_i;
    assign push0_val  = reg1WritebackEnable_i ? reg1WritebackVal_i     : reg2WritebackVal_i;

    wb_fifo #(
        .regWidth   (regWidth),
        .dataWidth  (dataWidth),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock_i),
        .reset       (reset_i),
        .push0_en    (push0_en),
        .push0_unit  (functionalUnitCode_i),
        .push0_addr  (push0_addr),
        .push0_val   (push0_val),
        .push1_en    (push1_en),
        .push1_unit  (functionalUnitCode_i),
        .push1_addr  (reg2WritebackAddress_i),
        .push1_val   (reg2WritebackVal_i),
        .pop         (pop),
        .head_unit   (head_unit),
        .head_addr   (head_addr),
        .head_val    (head_val),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Data outputs hold their last value when nothing drains.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            regWriteEnable_o  <= 1'b0;
            regWriteAddress_o <= '0;
            regWriteVal_o     <= '0;
            regWriteUnit_o    <= '0;
        end else begin
            regWriteEnable_o <= pop;
            if (pop) begin
                regWriteAddress_o <= head_addr;
                regWriteVal_o     <= head_val;
                regWriteUnit_o    <= head_unit;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            condReg_o            <= '0;
            condRegWriteEnable_o <= 1'b0;
            overflow_o           <= 1'b0;
        end else begin
            condRegWriteEnable_o <= accept && condRegUpdateEnable_i;
            if (accept && condRegUpdateEnable_i) condReg_o <= newCRVal_i;
            if (enable_i && stall_o) overflow_o <= 1'b1;
        end
    end

    // The drained entry stays pending while it sits on the write port,
    // since the GPR file only absorbs it at the following edge.
    always_comb begin
        pendingMask_o = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) pendingMask_o[entry_addr[i]] = 1'b1;
        end
        if (regWriteEnable_o) pendingMask_o[regWriteAddress_o] = 1'b1;
    end

endmodule
